// File: rtl/hdmi_pattern_gen.sv
// Test-pattern stage behind the HDMI timing generator: derives pixel X/Y from DE/VS,
// draws one of four frame-synchronous patterns and re-aligns sync/DE with a fixed 2-cycle latency.
module hdmi_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BAR_WIDTH  = 80,
    parameter int CHECK_LOG2 = 5,
    parameter int BOX_SIZE   = 64,
    parameter int BOX_STEP   = 2
) (
    input  logic        clock_25,
    input  logic        reset_n,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [1:0]  mode,
    input  logic        switch_red,
    input  logic        switch_green,
    input  logic        switch_blue,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic [23:0] rgb_out
);

    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE);
    localparam int BW    = 11;
    localparam int BOX_Y = (V_ACTIVE - BOX_SIZE) / 2;

    localparam logic [XW-1:0] X_MAX      = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] BOX_X_MAX  = BW'(H_ACTIVE - BOX_SIZE);
    localparam logic [BW-1:0] BOX_STEP_W = BW'(BOX_STEP);
    localparam logic [BW-1:0] BOX_SIZE_W = BW'(BOX_SIZE);
    localparam logic [YW-1:0] BOX_Y_TOP  = YW'(BOX_Y);
    localparam logic [YW-1:0] BOX_Y_BOT  = YW'(BOX_Y + BOX_SIZE);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          de1_q, hs1_q, vs1_q;
    logic [1:0]    mode_q, mode_d;
    logic [BW-1:0] box_x_q, box_x_d;
    logic          box_left_q, box_left_d;
    logic [23:0]   rgb_d;

    logic          vs_fall_s, de_fall_s;
    logic [23:0]   fg_s, fg_w_s, bar_rgb_s, pat_s;
    logic [31:0]   x32_s;
    logic [BW-1:0] x11_s;
    logic [2:0]    bar_idx_s;
    logic          in_box_s;

    assign vs_fall_s = vs1_q & ~vs_in;
    assign de_fall_s = de1_q & ~de_in;
    assign x32_s     = 32'(x_q);
    assign x11_s     = BW'(x_q);

    // Stage-1 next state: pixel counters, frame-latched mode and box motion
    always_comb begin
        x_d        = {XW{1'b0}};
        y_d        = y_q;
        mode_d     = mode_q;
        box_x_d    = box_x_q;
        box_left_d = box_left_q;
        if (de_in && de1_q) begin
            x_d = (x_q == X_MAX) ? x_q : x_q + XW'(1);
        end else begin
            x_d = {XW{1'b0}};
        end
        // A coincident VS edge takes priority so each frame starts on line 0
        if (vs_fall_s) begin
            y_d = {YW{1'b0}};
        end else if (de_fall_s && (y_q != Y_MAX)) begin
            y_d = y_q + YW'(1);
        end else begin
            y_d = y_q;
        end
        // Direction flips on reaching an edge so the box never dwells there for two frames
        if (vs_fall_s) begin
            mode_d = mode;
            if (!box_left_q) begin
                if (box_x_q + BOX_STEP_W >= BOX_X_MAX) begin
                    box_x_d    = BOX_X_MAX;
                    box_left_d = 1'b1;
                end else begin
                    box_x_d = box_x_q + BOX_STEP_W;
                end
            end else begin
                if (box_x_q <= BOX_STEP_W) begin
                    box_x_d    = {BW{1'b0}};
                    box_left_d = 1'b0;
                end else begin
                    box_x_d = box_x_q - BOX_STEP_W;
                end
            end
        end else begin
            mode_d = mode_q;
        end
    end

    // Stage-2 colour: pattern selection from the stage-1 pixel position
    always_comb begin
        fg_s   = {{8{switch_red}}, {8{switch_green}}, {8{switch_blue}}};
        fg_w_s = (fg_s == 24'h000000) ? 24'hFFFFFF : fg_s;
        bar_idx_s = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x32_s >= 32'(i * BAR_WIDTH)) begin
                bar_idx_s = bar_idx_s + 3'd1;
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
        case (bar_idx_s)
            3'd0:    bar_rgb_s = 24'hFFFFFF;
            3'd1:    bar_rgb_s = 24'hFFFF00;
            3'd2:    bar_rgb_s = 24'h00FFFF;
            3'd3:    bar_rgb_s = 24'h00FF00;
            3'd4:    bar_rgb_s = 24'hFF00FF;
            3'd5:    bar_rgb_s = 24'hFF0000;
            3'd6:    bar_rgb_s = 24'h0000FF;
            default: bar_rgb_s = 24'h000000;
        endcase
        in_box_s = (x11_s >= box_x_q) && (x11_s < box_x_q + BOX_SIZE_W) &&
                   (y_q >= BOX_Y_TOP) && (y_q < BOX_Y_BOT);
        case (mode_q)
            2'd0:    pat_s = fg_s;
            2'd1:    pat_s = bar_rgb_s;
            2'd2:    pat_s = (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) ? 24'h000000 : fg_w_s;
            2'd3:    pat_s = in_box_s ? fg_w_s : 24'h000000;
            default: pat_s = 24'h000000;
        endcase
        if (de1_q) begin
            rgb_d = pat_s;
        end else begin
            rgb_d = 24'h000000;
        end
    end

    // Stage-1 registers
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= {XW{1'b0}};
            y_q        <= {YW{1'b0}};
            de1_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            mode_q     <= 2'd0;
            box_x_q    <= {BW{1'b0}};
            box_left_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            de1_q      <= de_in;
            hs1_q      <= hs_in;
            vs1_q      <= vs_in;
            mode_q     <= mode_d;
            box_x_q    <= box_x_d;
            box_left_q <= box_left_d;
        end
    end

    // Stage-2 registers driving the transmitter
    always_ff @(posedge clock_25 or negedge reset_n) begin
        if (!reset_n) begin
            de_out  <= 1'b0;
            hs_out  <= 1'b1;
            vs_out  <= 1'b1;
            rgb_out <= 24'h000000;
        end else begin
            de_out  <= de1_q;
            hs_out  <= hs1_q;
            vs_out  <= vs1_q;
            rgb_out <= rgb_d;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Bench for hdmi_pattern_gen: directed phases plus randomized frames, every output cycle
// compared with a reference model built from run lengths, line counts and a triangle-wave box position.
module tb_hdmi_pattern_gen;

    logic        clock_25 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        switch_red = 1'b0, switch_green = 1'b0, switch_blue = 1'b0;
    logic        de_out, hs_out, vs_out;
    logic [23:0] rgb_out;

    always #20 clock_25 = ~clock_25;

    hdmi_pattern_gen dut (
        .clock_25(clock_25), .reset_n(reset_n),
        .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in), .mode(mode),
        .switch_red(switch_red), .switch_green(switch_green), .switch_blue(switch_blue),
        .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out), .rgb_out(rgb_out)
    );

    typedef struct {
        logic de; logic hs; logic vs;
        int x; int y; int mode; int box; int fr;
    } attr_t;

    int          checks = 0, errors = 0, phase = 0;
    int          run, lines, frames, mode_eff;
    logic        de_prev, vs_prev;
    logic        rand_sw = 1'b0, rand_mode = 1'b0;
    attr_t       prev_a, cur_a;
    logic [23:0] bars [8];

    function automatic int box_pos(input int n);
        int p;
        p = (2 * n) % 1152;
        return (p <= 576) ? p : 1152 - p;
    endfunction

    function automatic logic [23:0] colour(input attr_t a, input logic r, input logic g, input logic b);
        logic [23:0] fg, fgw;
        int bi;
        fg  = {{8{r}}, {8{g}}, {8{b}}};
        fgw = (fg == 24'h0) ? 24'hFFFFFF : fg;
        bi  = (a.x / 80 > 7) ? 7 : a.x / 80;
        if (!a.de) return 24'h0;
        case (a.mode)
            0:       return fg;
            1:       return bars[bi];
            2:       return (((a.x / 32) + (a.y / 32)) % 2 == 0) ? fgw : 24'h0;
            default: return (a.x >= a.box && a.x < a.box + 64 && a.y >= 208 && a.y < 272) ? fgw : 24'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; lines = 0; frames = 0; mode_eff = 0;
        de_prev = 1'b0; vs_prev = 1'b1;
        prev_a = '{de: 1'b0, hs: 1'b1, vs: 1'b1, x: 0, y: 0, mode: 0, box: 0, fr: 0};
    endtask

    task automatic spot();
        if (phase == 3) begin
            check("t3_solid", rgb_out, prev_a.de ? 24'hFF00FF : 24'h000000);
        end else if (prev_a.de && phase == 4) begin
            if (prev_a.x == 0 || prev_a.x == 79) check("t4_bar_white", rgb_out, 24'hFFFFFF);
            if (prev_a.x == 80)  check("t4_x80",  rgb_out, 24'hFFFF00);
            if (prev_a.x == 400) check("t4_x400", rgb_out, 24'hFF0000);
            if (prev_a.x == 639) check("t4_x639", rgb_out, 24'h000000);
        end else if (prev_a.de && phase == 5) begin
            if (prev_a.x == 0   && prev_a.y == 0)   check("t5_0_0",     rgb_out, 24'hFFFFFF);
            if (prev_a.x == 32  && prev_a.y == 0)   check("t5_32_0",    rgb_out, 24'h000000);
            if (prev_a.x == 32  && prev_a.y == 32)  check("t5_32_32",   rgb_out, 24'hFFFFFF);
            if (prev_a.x == 639 && prev_a.y == 479) check("t5_639_479", rgb_out, 24'h000000);
        end else if (prev_a.de && phase == 6 && prev_a.y == 208) begin
            if (prev_a.fr == 1   && prev_a.x == 1)   check("t6_f1_x1",     rgb_out, 24'h000000);
            if (prev_a.fr == 1   && prev_a.x == 2)   check("t6_f1_x2",     rgb_out, 24'hFF00FF);
            if (prev_a.fr == 288 && prev_a.x == 575) check("t6_f288_x575", rgb_out, 24'h000000);
            if (prev_a.fr == 288 && prev_a.x == 576) check("t6_f288_x576", rgb_out, 24'hFF00FF);
            if (prev_a.fr == 289 && prev_a.x == 573) check("t6_f289_x573", rgb_out, 24'h000000);
            if (prev_a.fr == 289 && prev_a.x == 574) check("t6_f289_x574", rgb_out, 24'hFF00FF);
            if (prev_a.fr == 289 && prev_a.x == 637) check("t6_f289_x637", rgb_out, 24'hFF00FF);
            if (prev_a.fr == 289 && prev_a.x == 638) check("t6_f289_x638", rgb_out, 24'h000000);
            if (prev_a.fr == 290 && prev_a.x == 0)   check("t6_midswitch_held", rgb_out, 24'hFFFFFF);
            if (prev_a.fr == 291 && prev_a.x == 0)   check("t6_switched_x0", rgb_out, 24'h000000);
            if (prev_a.fr == 291 && prev_a.x == 570) check("t6_switched_x570", rgb_out, 24'hFF00FF);
        end
    endtask

    // One clock: update the model for the inputs now applied, then compare the pixel two edges old
    task automatic tick();
        logic [23:0] exp_rgb;
        if (rand_sw) {switch_red, switch_green, switch_blue} = 3'($urandom_range(0, 7));
        if (vs_prev && !vs_in) begin
            frames++; mode_eff = int'(mode); lines = 0;
        end else if (de_prev && !de_in) begin
            lines++;
        end
        run = de_in ? run + 1 : 0;
        cur_a.de = de_in; cur_a.hs = hs_in; cur_a.vs = vs_in;
        cur_a.x = de_in ? ((run - 1 > 639) ? 639 : run - 1) : 0;
        cur_a.y = (lines > 479) ? 479 : lines;
        cur_a.mode = mode_eff; cur_a.box = box_pos(frames); cur_a.fr = frames;
        exp_rgb = colour(prev_a, switch_red, switch_green, switch_blue);
        @(posedge clock_25);
        #1;
        check("de_out", {23'd0, de_out}, {23'd0, prev_a.de});
        check("hs_out", {23'd0, hs_out}, {23'd0, prev_a.hs});
        check("vs_out", {23'd0, vs_out}, {23'd0, prev_a.vs});
        check("rgb_out", rgb_out, exp_rgb);
        spot();
        prev_a = cur_a; de_prev = de_in; vs_prev = vs_in;
    endtask

    task automatic drive(input logic de, input logic hs, input logic vs);
        de_in = de; hs_in = hs; vs_in = vs;
        tick();
    endtask

    task automatic line(input int n);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (rand_mode && $urandom_range(0, 255) == 0) mode = 2'($urandom_range(0, 3));
            drive(1'b1, 1'b1, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b1);
    endtask

    task automatic vsync();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear before any edge
    task automatic async_reset();
        #5 reset_n = 1'b0;
        #1;
        check("rst_de",  {23'd0, de_out}, 24'd0);
        check("rst_hs",  {23'd0, hs_out}, 24'd1);
        check("rst_vs",  {23'd0, vs_out}, 24'd1);
        check("rst_rgb", rgb_out, 24'h000000);
        model_reset();
        hs_in = 1'b1; vs_in = 1'b1;
        #4 reset_n = 1'b1;
    endtask

    initial begin
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        model_reset();
        repeat (2) @(posedge clock_25);
        #1;
        check("init_de",  {23'd0, de_out}, 24'd0);
        check("init_hs",  {23'd0, hs_out}, 24'd1);
        check("init_vs",  {23'd0, vs_out}, 24'd1);
        check("init_rgb", rgb_out, 24'h000000);
        reset_n = 1'b1;

        // Latency: a single DE pulse emerges exactly two edges later
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        check("t2_lat1", {23'd0, de_out}, 24'd0);
        drive(1'b0, 1'b0, 1'b1);
        check("t2_lat2", {23'd0, de_out}, 24'd1);
        drive(1'b0, 1'b1, 1'b1);
        check("t2_lat3", {23'd0, de_out}, 24'd0);
        check("t2_hs",   {23'd0, hs_out}, 24'd0);

        // Solid colour
        {switch_red, switch_green, switch_blue} = 3'b101;
        mode = 2'd0;
        vsync();
        phase = 3;
        line(640); line(640);
        phase = 0;

        // Colour bars with changing switches
        rand_sw = 1'b1; mode = 2'd1;
        vsync();
        phase = 4;
        line(640); line(700);
        phase = 0;

        // Checkerboard, black switches promoted to white, Y saturation
        rand_sw = 1'b0; {switch_red, switch_green, switch_blue} = 3'b000;
        mode = 2'd2;
        vsync();
        phase = 5;
        line(640);
        repeat (31) line(1);
        line(640);
        repeat (446) line(1);
        line(700); line(640);
        phase = 0;

        // Moving box from a fresh reset, including a mid-frame mode switch
        drive(1'b1, 1'b1, 1'b1);
        async_reset();
        drive(1'b1, 1'b1, 1'b1); drive(1'b1, 1'b1, 1'b1); drive(1'b0, 1'b1, 1'b1);
        {switch_red, switch_green, switch_blue} = 3'b101;
        mode = 2'd3;
        phase = 6;
        for (int f = 1; f <= 291; f++) begin
            if (f == 290) mode = 2'd1;
            vsync();
            if (f == 1 || f >= 288) begin
                repeat (208) line(1);
                if (f == 290) mode = 2'd3;
                line(640);
            end
        end
        phase = 0;

        // Randomized frames: switches, line lengths and mid-frame mode writes
        rand_sw = 1'b1; rand_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            mode = 2'($urandom_range(0, 3));
            vsync();
            repeat ($urandom_range(190, 240)) line(int'($urandom_range(1, 3)));
            repeat (4) line(int'($urandom_range(500, 720)));
            if (f == 1) begin
                drive(1'b1, 1'b1, 1'b1); drive(1'b1, 1'b1, 1'b1);
                async_reset();
                repeat (5) drive(1'b1, 1'b1, 1'b1);
                drive(1'b0, 1'b1, 1'b1);
            end
        end
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
